decode_stage: RTL

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_pkg.sv | 59 +++++
 rtl/decode_stage_gpr_file.sv | 54 +++++
 rtl/decode_stage.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/decode_pkg.sv
// Shared decode types: ALU/memory/branch operation enums, RV32I opcodes and GPR count.
package decode_pkg;

  localparam int unsigned REG_COUNT = 32;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_SLTU   = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_PASS_B = 4'd10
  } alu_op_e;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'b00,
    MEM_LOAD  = 2'b01,
    MEM_STORE = 2'b10
  } mem_op_e;

  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_COND = 2'b01,
    BR_JAL  = 2'b10,
    BR_JALR = 2'b11
  } br_kind_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // alt selects SUB/SRA; callers gate it to the encodings where it is meaningful.
  function automatic alu_op_e alu_from_funct(input logic [2:0] f3, input logic alt);
    alu_op_e op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/decode_stage_gpr_file.sv
// General-purpose register file: three combinational read ports, one write port.
// DECODE_WB_BYPASS_EN forwards same-cycle write data to every read port.
module gpr_file
  import decode_pkg::*;
#(
  parameter int unsigned REG_COUNT = decode_pkg::REG_COUNT
) (
  input  logic        _clk,
  input  logic        _reset,
  input  logic        _we,
  input  logic [4:0]  _waddr,
  input  logic [31:0] _wdata,
  input  logic [4:0]  _raddr_a,
  input  logic [4:0]  _raddr_b,
  input  logic [4:0]  _raddr_c,
  output logic [31:0] rdata_a_,
  output logic [31:0] rdata_b_,
  output logic [31:0] rdata_c_
);

  logic [31:0] regs [REG_COUNT];
  logic        wr_hit_en;

  assign wr_hit_en = _we && (_waddr != '0);

  always_ff @(posedge _clk) begin
    if (_reset) begin
      regs <= '{default: '0};
    end else if (wr_hit_en && (32'(_waddr) < REG_COUNT)) begin
      regs[_waddr] <= _wdata;
    end
  end

  function automatic logic [31:0] read_port(input logic [4:0] idx);
    logic [31:0] val;
    val = '0;
    if (idx != '0 && 32'(idx) < REG_COUNT) begin
      val = regs[idx];
`ifdef DECODE_WB_BYPASS_EN
      if (wr_hit_en && _waddr == idx) begin
        val = _wdata;
      end
`endif
    end
    return val;
  endfunction

  always_comb begin
    rdata_a_ = read_port(_raddr_a);
    rdata_b_ = read_port(_raddr_b);
    rdata_c_ = read_port(_raddr_c);
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: one-cycle registered decode with flush/stall and GPR read.
// Optional DECODE_WB_BYPASS_EN enables writeback-to-read forwarding in gpr_file.
module decode_stage
  import decode_pkg::*;
#(
  parameter int unsigned REG_COUNT = decode_pkg::REG_COUNT
) (
  input  logic        _clk,
  input  logic        _reset,
  input  logic [31:0] _f_pc,
  input  logic [31:0] _f_inst,
  input  logic [31:0] _f_target_branch,
  input  logic        _f_is_taken,
  input  logic        _f_valid,
  input  logic        _wb_we,
  input  logic [4:0]  _wb_rd,
  input  logic [31:0] _wb_data,
  input  logic        _sig_invalid_prediction,
  input  logic        _sig_exec_lw_block,
  input  logic [4:0]  _fetch_rs1,
  output logic [31:0] gpr_fetch_,
  output logic [31:0] pc_,
  output logic [31:0] rs1_val_,
  output logic [31:0] rs2_val_,
  output logic [31:0] imm_,
  output logic [4:0]  rd_,
  output logic        wb_we_,
  output alu_op_e     alu_op_,
  output mem_op_e     mem_op_,
  output br_kind_e    br_kind_,
  output logic [31:0] target_branch_,
  output logic        is_taken_,
  output logic        illegal_,
  output logic        valid_
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1_rd, rs2_rd;

  logic [31:0] d_imm;
  logic [4:0]  d_rd;
  logic        d_writes;
  logic        d_illegal;
  alu_op_e     d_alu;
  mem_op_e     d_mem;
  br_kind_e    d_br;

  assign opcode = _f_inst[6:0];
  assign funct3 = _f_inst[14:12];
  assign funct7 = _f_inst[31:25];
  assign imm_i  = {{20{_f_inst[31]}}, _f_inst[31:20]};
  assign imm_s  = {{20{_f_inst[31]}}, _f_inst[31:25], _f_inst[11:7]};
  assign imm_b  = {{20{_f_inst[31]}}, _f_inst[7], _f_inst[30:25], _f_inst[11:8], 1'b0};
  assign imm_u  = {_f_inst[31:12], 12'h000};
  assign imm_j  = {{12{_f_inst[31]}}, _f_inst[19:12], _f_inst[20], _f_inst[30:21], 1'b0};

  // Without bypass, hazard logic outside this stage must add one stall cycle on a same-cycle WB read.
  gpr_file #(.REG_COUNT(REG_COUNT)) u_gpr (
    ._clk     (_clk),
    ._reset   (_reset),
    ._we      (_wb_we),
    ._waddr   (_wb_rd),
    ._wdata   (_wb_data),
    ._raddr_a (_f_inst[19:15]),
    ._raddr_b (_f_inst[24:20]),
    ._raddr_c (_fetch_rs1),
    .rdata_a_ (rs1_rd),
    .rdata_b_ (rs2_rd),
    .rdata_c_ (gpr_fetch_)
  );

  always_comb begin
    d_imm     = '0;
    d_writes  = 1'b0;
    d_illegal = 1'b0;
    d_alu     = ALU_ADD;
    d_mem     = MEM_NONE;
    d_br      = BR_NONE;
    case (opcode)
      OPC_LUI: begin
        d_imm = imm_u; d_writes = 1'b1; d_alu = ALU_PASS_B;
      end
      OPC_AUIPC: begin
        d_imm = imm_u; d_writes = 1'b1;
      end
      OPC_JAL: begin
        d_imm = imm_j; d_writes = 1'b1; d_br = BR_JAL;
      end
      OPC_JALR: begin
        d_imm = imm_i; d_writes = 1'b1; d_br = BR_JALR;
        d_illegal = (funct3 != 3'b000);
      end
      OPC_BRANCH: begin
        d_imm = imm_b; d_br = BR_COND;
        d_alu = funct3[2] ? (funct3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB;
        d_illegal = (funct3[2:1] == 2'b01);
      end
      OPC_LOAD: begin
        d_imm = imm_i; d_writes = 1'b1; d_mem = MEM_LOAD;
        d_illegal = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
      end
      OPC_STORE: begin
        d_imm = imm_s; d_mem = MEM_STORE;
        d_illegal = funct3[2] || (funct3 == 3'b011);
      end
      OPC_OPIMM: begin
        d_imm = imm_i; d_writes = 1'b1;
        d_alu = alu_from_funct(funct3, (funct3 == 3'b101) && funct7[5]);
        d_illegal = ((funct3 == 3'b001) && (funct7 != 7'b0000000)) ||
                    ((funct3 == 3'b101) && ((funct7 & 7'b1011111) != 7'b0000000));
      end
      OPC_OP: begin
        d_writes = 1'b1;
        d_alu = alu_from_funct(funct3, funct7[5]);
        d_illegal = ((funct7 & 7'b1011111) != 7'b0000000) ||
                    (funct7[5] && (funct3 != 3'b000) && (funct3 != 3'b101));
      end
      default: d_illegal = 1'b1;
    endcase
    if (d_illegal) begin
      d_imm    = '0;
      d_writes = 1'b0;
      d_alu    = ALU_ADD;
      d_mem    = MEM_NONE;
      d_br     = BR_NONE;
    end
  end

  assign d_rd = d_writes ? _f_inst[11:7] : '0;

  always_ff @(posedge _clk) begin
    if (_reset) begin
      pc_            <= '0;
      rs1_val_       <= '0;
      rs2_val_       <= '0;
      imm_           <= '0;
      rd_            <= '0;
      wb_we_         <= 1'b0;
      alu_op_        <= ALU_ADD;
      mem_op_        <= MEM_NONE;
      br_kind_       <= BR_NONE;
      target_branch_ <= '0;
      is_taken_      <= 1'b0;
      illegal_       <= 1'b0;
      valid_         <= 1'b0;
    end else if (_sig_invalid_prediction) begin
      valid_   <= 1'b0;
      wb_we_   <= 1'b0;
      mem_op_  <= MEM_NONE;
      br_kind_ <= BR_NONE;
    end else if (!_sig_exec_lw_block) begin
      pc_            <= _f_pc;
      rs1_val_       <= rs1_rd;
      rs2_val_       <= rs2_rd;
      imm_           <= d_imm;
      rd_            <= d_rd;
      alu_op_        <= d_alu;
      target_branch_ <= _f_target_branch;
      is_taken_      <= _f_is_taken;
      valid_         <= _f_valid;
      wb_we_         <= _f_valid && d_writes && (d_rd != '0);
      mem_op_        <= _f_valid ? d_mem : MEM_NONE;
      br_kind_       <= _f_valid ? d_br : BR_NONE;
      illegal_       <= _f_valid && d_illegal;
    end
  end

endmodule
